// File: rtl/gamepad_pkg.sv
// Shared definitions for the gamepad decoder: debounce FSM states, the
// "no button" code and the stability-counter width helper.
package gamepad_pkg;

  typedef enum logic {
    ST_WAIT   = 1'b0,
    ST_STABLE = 1'b1
  } db_state_t;

  localparam int unsigned CODE_NONE = 0;

  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/gamepad_debounce.sv
// Two-flop synchroniser plus a restart-on-change stability counter that emits
// exactly one commit strobe per stable period of the {sel, code} sample.
module gamepad_debounce
  import gamepad_pkg::*;
#(
  parameter int SEL_W         = 1,
  parameter int CODE_W        = 4,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [CODE_W-1:0] i_code,
  output logic              o_commit,
  output logic [SEL_W-1:0]  o_sel,
  output logic [CODE_W-1:0] o_code
);

  localparam int SAMP_W = SEL_W + CODE_W;
  localparam int CNT_W  = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SAMP_W-1:0] r_sync1;
  logic [SAMP_W-1:0] r_samp;
  logic [SAMP_W-1:0] r_prev;
  logic [CNT_W-1:0]  r_cnt;
  db_state_t         r_state;
  db_state_t         w_state_nxt;
  logic              w_change;
  logic              w_commit;

  assign w_change = (r_samp != r_prev);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_samp  <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
      r_state <= ST_WAIT;
    end else begin
      r_sync1 <= {i_sel, i_code};
      r_samp  <= r_sync1;
      r_prev  <= r_samp;
      if (w_change) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_state <= w_state_nxt;
    end
  end

  // A change in the terminal-count cycle wins: no commit, counter restarts.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (!w_change && (r_cnt == CNT_MAX)) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (w_change) begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  assign o_commit = w_commit;
  assign {o_sel, o_code} = r_samp;

endmodule

// File: rtl/gamepad_decoder.sv
// Turns debounced {sel, code} commits into per-controller one-hot button
// state plus press/release event strobes and an invalid-sample error pulse.
module gamepad_decoder
  import gamepad_pkg::*;
#(
  parameter int NUM_CTRL      = 2,
  parameter int SEL_W         = 1,
  parameter int CODE_W        = 4,
  parameter int NUM_BTN       = 10,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [CODE_W-1:0]           i_code_in,
  input  logic [SEL_W-1:0]            i_sel_in,
  output logic [NUM_CTRL*NUM_BTN-1:0] o_btn_state,
  output logic                        o_evt_valid,
  output logic                        o_evt_press,
  output logic [SEL_W-1:0]            o_evt_ctrl,
  output logic [CODE_W-1:0]           o_evt_btn,
  output logic                        o_err_pulse
);

  localparam logic [SEL_W:0]    NUM_CTRL_V = (SEL_W + 1)'(NUM_CTRL);
  localparam logic [CODE_W-1:0] NUM_BTN_V  = CODE_W'(NUM_BTN);
  localparam logic [CODE_W-1:0] NONE       = CODE_W'(CODE_NONE);

  logic              w_commit;
  logic [SEL_W-1:0]  w_sel;
  logic [CODE_W-1:0] w_code;
  logic [CODE_W-1:0] w_sel_held;
  logic              w_invalid;
  logic              w_write;

  logic [CODE_W-1:0] r_held [NUM_CTRL];
  logic              r_evt_valid;
  logic              r_evt_press;
  logic [SEL_W-1:0]  r_evt_ctrl;
  logic [CODE_W-1:0] r_evt_btn;
  logic              r_err_pulse;
  logic              r_pend_valid;
  logic [SEL_W-1:0]  r_pend_ctrl;
  logic [CODE_W-1:0] r_pend_btn;

  gamepad_debounce #(
    .SEL_W        (SEL_W),
    .CODE_W       (CODE_W),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_sel   (i_sel_in),
    .i_code  (i_code_in),
    .o_commit(w_commit),
    .o_sel   (w_sel),
    .o_code  (w_code)
  );

  always_comb begin
    w_sel_held = NONE;
    for (int c = 0; c < NUM_CTRL; c++) begin
      if (w_sel == SEL_W'(c)) begin
        w_sel_held = r_held[c];
      end
    end
  end

  assign w_invalid = ({1'b0, w_sel} >= NUM_CTRL_V) || (w_code > NUM_BTN_V);
  assign w_write   = w_commit && !w_invalid && (w_code != w_sel_held);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < NUM_CTRL; c++) begin
        r_held[c] <= NONE;
      end
      r_evt_valid  <= 1'b0;
      r_evt_press  <= 1'b0;
      r_evt_ctrl   <= '0;
      r_evt_btn    <= '0;
      r_err_pulse  <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_ctrl  <= '0;
      r_pend_btn   <= '0;
    end else begin
      r_evt_valid <= 1'b0;
      r_err_pulse <= 1'b0;
      // Deferred release of the button displaced by a press.
      if (r_pend_valid) begin
        r_evt_valid  <= 1'b1;
        r_evt_press  <= 1'b0;
        r_evt_ctrl   <= r_pend_ctrl;
        r_evt_btn    <= r_pend_btn;
        r_pend_valid <= 1'b0;
      end
      if (w_commit) begin
        if (w_invalid) begin
          r_err_pulse <= 1'b1;
        end else if (w_code == NONE) begin
          if (w_sel_held != NONE) begin
            r_evt_valid <= 1'b1;
            r_evt_press <= 1'b0;
            r_evt_ctrl  <= w_sel;
            r_evt_btn   <= w_sel_held;
          end
        end else if (w_code != w_sel_held) begin
          r_evt_valid <= 1'b1;
          r_evt_press <= 1'b1;
          r_evt_ctrl  <= w_sel;
          r_evt_btn   <= w_code;
          if (w_sel_held != NONE) begin
            r_pend_valid <= 1'b1;
            r_pend_ctrl  <= w_sel;
            r_pend_btn   <= w_sel_held;
          end
        end
      end
      for (int c = 0; c < NUM_CTRL; c++) begin
        if (w_write && (w_sel == SEL_W'(c))) begin
          r_held[c] <= w_code;
        end
      end
    end
  end

  always_comb begin
    o_btn_state = '0;
    for (int c = 0; c < NUM_CTRL; c++) begin
      for (int b = 0; b < NUM_BTN; b++) begin
        o_btn_state[c*NUM_BTN + b] = (r_held[c] == CODE_W'(b + 1));
      end
    end
  end

  assign o_evt_valid = r_evt_valid;
  assign o_evt_press = r_evt_press;
  assign o_evt_ctrl  = r_evt_ctrl;
  assign o_evt_btn   = r_evt_btn;
  assign o_err_pulse = r_err_pulse;

endmodule

// File: tb/tb_gamepad_decoder.sv
// Self-checking bench for gamepad_decoder: directed table, hand sequences for
// latency/reset corners, and random stimulus against a run-length model.
module tb_gamepad_decoder;

  localparam int NC = 2;
  localparam int SW = 1;
  localparam int CW = 4;
  localparam int NB = 10;
  localparam int SC = 8;
  localparam int BW = NC * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] code;
  logic [SW-1:0] sel;
  logic [BW-1:0] btn;
  logic          ev_valid, ev_press, err;
  logic [SW-1:0] ev_ctrl;
  logic [CW-1:0] ev_btn;

  logic [CW-1:0] code3;
  logic [1:0]    sel3;
  logic [29:0]   btn3;
  logic          ev3_valid, ev3_press, err3;
  logic [1:0]    ev3_ctrl;
  logic [CW-1:0] ev3_btn;

  always #5 clk = ~clk;

  gamepad_decoder #(.NUM_CTRL(NC), .SEL_W(SW), .CODE_W(CW), .NUM_BTN(NB),
                    .STABLE_CYCLES(SC)) dut (
    .i_clock(clk), .i_reset(rst), .i_code_in(code), .i_sel_in(sel),
    .o_btn_state(btn), .o_evt_valid(ev_valid), .o_evt_press(ev_press),
    .o_evt_ctrl(ev_ctrl), .o_evt_btn(ev_btn), .o_err_pulse(err)
  );

  gamepad_decoder #(.NUM_CTRL(3), .SEL_W(2), .CODE_W(CW), .NUM_BTN(NB),
                    .STABLE_CYCLES(SC)) dut3 (
    .i_clock(clk), .i_reset(rst), .i_code_in(code3), .i_sel_in(sel3),
    .o_btn_state(btn3), .o_evt_valid(ev3_valid), .o_evt_press(ev3_press),
    .o_evt_ctrl(ev3_ctrl), .o_evt_btn(ev3_btn), .o_err_pulse(err3)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a sample is committed when it has been seen unchanged
  // (two cycles after the pins) for exactly SC consecutive cycles.
  typedef struct {bit press; int ctrl; int btnc;} ev_t;
  logic [SW+CW-1:0] m_s1, m_samp, m_prev;
  int  m_run;
  int  m_held[NC];
  ev_t m_q[$];
  bit  e_valid, e_press, e_err;
  int  e_ctrl, e_btn;

  function automatic logic [BW-1:0] model_btn();
    logic [BW-1:0] v = '0;
    for (int c = 0; c < NC; c++)
      if (m_held[c] != 0) v[c*NB + m_held[c] - 1] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_samp = '0; m_prev = '0; m_run = 0;
    for (int c = 0; c < NC; c++) m_held[c] = 0;
    m_q.delete();
    e_valid = 0; e_press = 0; e_err = 0; e_ctrl = 0; e_btn = 0;
  endtask

  task automatic model_step();
    int s, k;
    ev_t ev;
    if (m_samp == m_prev) m_run++; else m_run = 0;
    e_valid = 0; e_err = 0;
    if (m_run == SC) begin
      s = int'(m_samp[SW+CW-1:CW]);
      k = int'(m_samp[CW-1:0]);
      if (s >= NC || k > NB) e_err = 1;
      else if (k == 0) begin
        if (m_held[s] != 0) begin
          m_q.push_back('{1'b0, s, m_held[s]});
          m_held[s] = 0;
        end
      end else if (k != m_held[s]) begin
        m_q.push_back('{1'b1, s, k});
        if (m_held[s] != 0) m_q.push_back('{1'b0, s, m_held[s]});
        m_held[s] = k;
      end
    end
    if (m_q.size() > 0) begin
      ev = m_q.pop_front();
      e_valid = 1; e_press = ev.press; e_ctrl = ev.ctrl; e_btn = ev.btnc;
    end
    m_prev = m_samp;
    m_samp = m_s1;
    m_s1   = {sel, code};
  endtask

  int cnt_press, cnt_rel, cnt_err, cnt3_err, cnt3_ev, last3_ctrl, last3_btn;

  task automatic clear_counts();
    cnt_press = 0; cnt_rel = 0; cnt_err = 0; cnt3_err = 0; cnt3_ev = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    cyc++;
    chk("btn_state", 32'(btn), 32'(model_btn()));
    chk("evt_valid", 32'(ev_valid), 32'(e_valid));
    chk("err_pulse", 32'(err), 32'(e_err));
    if (e_valid) begin
      chk("evt_press", 32'(ev_press), 32'(e_press));
      chk("evt_ctrl", 32'(ev_ctrl), e_ctrl);
      chk("evt_btn", 32'(ev_btn), e_btn);
    end
    if (ev_valid) begin
      if (ev_press) cnt_press++; else cnt_rel++;
    end
    if (err) cnt_err++;
    if (err3) cnt3_err++;
    if (ev3_valid && ev3_press) begin
      cnt3_ev++; last3_ctrl = int'(ev3_ctrl); last3_btn = int'(ev3_btn);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_btn"}, 32'(btn), 0);
    chk({tag, "_valid"}, 32'(ev_valid), 0);
    chk({tag, "_press"}, 32'(ev_press), 0);
    chk({tag, "_ctrl"}, 32'(ev_ctrl), 0);
    chk({tag, "_evbtn"}, 32'(ev_btn), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_btn3"}, 32'(btn3), 0);
  endtask

  typedef struct {
    logic [SW-1:0] sel;
    logic [CW-1:0] code;
    int            hold;
    logic [BW-1:0] exp_btn;
    int            exp_press;
    int            exp_rel;
    int            exp_err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n;
    bit found;
    tbl[0]  = '{1'b0, 4'd7,  20, 20'h00040, 1, 1, 0};
    tbl[1]  = '{1'b1, 4'd10, 20, 20'h80040, 1, 0, 0};
    tbl[2]  = '{1'b1, 4'd0,  20, 20'h00040, 0, 1, 0};
    tbl[3]  = '{1'b0, 4'd12, 20, 20'h00040, 0, 0, 1};
    tbl[4]  = '{1'b0, 4'd7,  20, 20'h00040, 0, 0, 0};
    tbl[5]  = '{1'b0, 4'd0,  20, 20'h00000, 0, 1, 0};
    tbl[6]  = '{1'b1, 4'd0,  20, 20'h00000, 0, 0, 0};
    tbl[7]  = '{1'b0, 4'd10, 20, 20'h00200, 1, 0, 0};
    tbl[8]  = '{1'b0, 4'd11, 20, 20'h00200, 0, 0, 1};
    tbl[9]  = '{1'b0, 4'd1,  20, 20'h00001, 1, 1, 0};
    tbl[10] = '{1'b1, 4'd1,  20, 20'h00401, 1, 0, 0};

    code = '0; sel = '0; code3 = '0; sel3 = '0;
    last3_ctrl = 0; last3_btn = 0;
    model_reset();
    clear_counts();
    rst = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    #1 rst = 1'b0;

    // Toggling faster than the stability window never commits.
    repeat (12) tick();
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      code = (i % 2 == 0) ? 4'd3 : 4'd0;
      repeat (4) tick();
    end
    chk("toggle_events", cnt_press + cnt_rel, 0);
    chk("toggle_btn", 32'(btn), 0);

    // Latency from pin change to btn_state.
    clear_counts();
    code = 4'd3; sel = 1'b0;
    n = 0; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      n++;
      if (btn[9:0] == 10'h004) found = 1;
    end
    chk("latency_seen", 32'(found), 1);
    chk("latency", n, 11);
    repeat (9) tick();
    chk("press3_count", cnt_press, 1);
    chk("press3_rel", cnt_rel, 0);

    for (int i = 0; i < 11; i++) begin
      clear_counts();
      sel = tbl[i].sel; code = tbl[i].code;
      repeat (tbl[i].hold) tick();
      chk($sformatf("tbl%0d_btn", i), 32'(btn), 32'(tbl[i].exp_btn));
      chk($sformatf("tbl%0d_press", i), cnt_press, tbl[i].exp_press);
      chk($sformatf("tbl%0d_rel", i), cnt_rel, tbl[i].exp_rel);
      chk($sformatf("tbl%0d_err", i), cnt_err, tbl[i].exp_err);
    end

    // Three-controller instance: select 3 is out of range.
    clear_counts();
    sel3 = 2'd3; code3 = 4'd2;
    repeat (20) tick();
    chk("c3_err", cnt3_err, 1);
    chk("c3_err_btn", 32'(btn3), 0);
    chk("c3_err_ev", cnt3_ev, 0);
    clear_counts();
    sel3 = 2'd2; code3 = 4'd5;
    repeat (20) tick();
    chk("c3_btn", 32'(btn3), 32'h0100_0000);
    chk("c3_ev", cnt3_ev, 1);
    chk("c3_ctrl", last3_ctrl, 2);
    chk("c3_evbtn", last3_btn, 5);

    for (int i = 0; i < 250; i++) begin
      sel  = SW'($urandom_range(0, 1));
      code = CW'($urandom_range(0, 15));
      repeat ($urandom_range(1, 14)) tick();
    end

    // Reset in the middle of a stability count.
    sel = 1'b0; code = 4'd5;
    repeat (5) tick();
    #1 rst = 1'b1;
    #1 model_reset();
    chk_all_zero("rst_count");
    repeat (3) tick();
    #1 rst = 1'b0;
    repeat (20) tick();
    code = 4'd3;
    repeat (20) tick();

    // Reset while the displaced-button release is pending.
    code = 4'd7;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (ev_valid && ev_press) found = 1;
    end
    chk("deferred_press_seen", 32'(found), 1);
    #1 rst = 1'b1; code = 4'd0;
    #1 model_reset();
    chk_all_zero("rst_deferred");
    repeat (2) tick();
    #1 rst = 1'b0;
    clear_counts();
    repeat (25) tick();
    chk("post_reset_events", cnt_press + cnt_rel, 0);
    chk("post_reset_btn", 32'(btn), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gamepad_decoder.md
Name: gamepad_decoder

Overview:
- Parametrised successor to the existing single-pair PS2/Arduino button latch. Decodes a binary button code plus a controller-select field from the GPIO header into per-controller one-hot button-state vectors.
- Adds an input synchroniser and a proper stability (debounce) counter that restarts on any change. Adds release detection, plus press/release event strobes for up to NUM_CTRL controllers.
- Sits between the GPIO pins and game logic; the game logic consumes the btn_state vectors and the evt_* strobes.

Parameters:
- NUM_CTRL, 2, number of controllers (>=1)
- SEL_W, 1, width of the controller-select field; must satisfy 2**SEL_W >= NUM_CTRL
- CODE_W, 4, width of the button code; code 0 = no button
- NUM_BTN, 10, number of buttons; valid codes are 1..NUM_BTN, and NUM_BTN <= 2**CODE_W-1
- STABLE_CYCLES, 1000000, cycles a sample must remain unchanged before it is committed (>=2)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- code_in  in  CODE_W  raw button code from GPIO (asynchronous)
- sel_in  in  SEL_W  raw controller select from GPIO (asynchronous)
- btn_state  out  NUM_CTRL*NUM_BTN  held-button one-hot per controller; controller c occupies bits [c*NUM_BTN +: NUM_BTN], and button k maps to bit k-1
- evt_valid  out  1  one-cycle strobe marking an event
- evt_press  out  1  qualified by evt_valid: 1 = press, 0 = release
- evt_ctrl  out  SEL_W  controller index of the event
- evt_btn  out  CODE_W  button code (1..NUM_BTN) of the event
- err_pulse  out  1  one-cycle strobe when a committed sample is invalid

Behaviour:
- Reset (async, active-high): all outputs 0, synchroniser flops 0, counter 0, FSM to WAIT, committed sample = {sel 0, code 0}.
- Synchroniser: {sel_in, code_in} passes through two flops to form `samp`; `prev` holds samp delayed one cycle.
- Stability counter, width clog2(STABLE_CYCLES):
  - Cleared whenever samp != prev.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- FSM:
  - WAIT: when samp == prev and cnt == STABLE_CYCLES-1, commit samp and go to STABLE.
  - STABLE: when samp != prev, clear the counter and go to WAIT. Exactly one commit occurs per stable period; no repeat commits.
  - If a change lands in the same cycle as the terminal count, there is no commit and the counter restarts.
- Commit of {s, k} (outputs registered, visible the cycle after the commit decision):
  - s >= NUM_CTRL, or k > NUM_BTN: err_pulse=1 for one cycle; no state change, no event.
  - k == 0: if controller s holds button j, clear it and emit a release event (ctrl s, btn j). If nothing is held, no event.
  - k valid, same as the held button: no event.
  - k valid, nothing held: set bit k-1 and emit a press event.
  - k valid, a different button j is held: set bit k-1, clear bit j-1, and emit a press event for k. The release of j is emitted on the following cycle, so evt_valid is high for two consecutive cycles, press first.
- Only the selected controller changes on a commit; all other controllers hold their state.
- A press commit on controller A followed by a commit on controller B leaves A's button held until A is explicitly committed with code 0.
- Each controller holds at most one button at a time (one-hot or zero).
- End-to-end latency from an input change to btn_state: 2 sync cycles + STABLE_CYCLES + 1 register cycle.
- Reset asserted mid-count or mid-event clears everything immediately; a pending deferred release is discarded.

Decomposition:
- Shared package gamepad_pkg holds:
  - FSM state encoding (WAIT, STABLE)
  - the code-0 NONE constant
  - a function to compute the counter width
- Natural sub-module: gamepad_debounce. It contains the synchroniser, stability counter and FSM, and outputs a commit strobe plus the committed {sel, code}.
- The top level contains commit decoding, the per-controller state registers and the event logic.

Test Plan (STABLE_CYCLES=8, NUM_CTRL=2, NUM_BTN=10):
- code=3, sel=0 held 20 cycles -> btn_state[9:0]=0x004 at cycle 2+8+1 after the change. One evt_valid with press=1, ctrl=0, btn=3; no further events while held.
- code toggles 3/0 every 4 cycles for 40 cycles -> no commit, btn_state stays 0, evt_valid never asserted.
- Controller 0 holding 3, then code=7 stable -> btn_state[9:0]=0x040. Press btn 7, then release btn 3 on the next cycle.
- sel=1, code=10 stable, then code=0 stable -> btn_state[19:10] goes 0x200 then 0. Press then release events on ctrl 1; controller 0 bits unchanged throughout.
- code=12 stable -> err_pulse for 1 cycle, no event, btn_state unchanged. Separately, with NUM_CTRL=3 and SEL_W=2, sel=3 stable -> err_pulse.
- reset asserted during a count and during a deferred release -> all outputs 0 asynchronously; no event after deassertion until a new stable sample arrives.
